// File: rtl/mux_pkg.sv
// Shared constants for the registered 8-to-1 lane picker.
// Pipeline depth depends on MUX_81_PIPE_EN (see mux_81).
package mux_pkg;
    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;
    localparam int LAT_COMB  = 1;
    localparam int LAT_PIPE  = 3;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_81_if.sv
// Lane/select/result bundle for mux_81; the requester drives lanes and selects,
// the mux returns the registered result on y.
interface mux_81_if
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic [NUM_LANES*WIDTH-1:0] data;
    logic                       s2;
    logic                       s1;
    logic                       s0;
    logic [WIDTH-1:0]           y;

    modport master (output data, output s2, output s1, output s0, input y);
    modport slave  (input data, input s2, input s1, input s0, output y);
endinterface

// File: rtl/mux_21.sv
// 2-to-1 cell; a plain ternary so X/Z on sel propagates rather than being masked.
module mux_21 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

// File: rtl/mux_81.sv
// Registered 8-to-1 mux as a three-level tree of mux_21 cells (s0, s1, s2).
// Define MUX_81_PIPE_EN to register after levels 1 and 2 (latency 3 instead of 1).
module mux_81
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    mux_81_if.slave  bus
);
    localparam int N1 = NUM_LANES / 2;
    localparam int N2 = NUM_LANES / 4;

    logic [NUM_LANES-1:0][WIDTH-1:0] lane;
    logic [N1-1:0][WIDTH-1:0]        l1;
    logic [N1-1:0][WIDTH-1:0]        l1_src;
    logic [N2-1:0][WIDTH-1:0]        l2;
    logic [N2-1:0][WIDTH-1:0]        l2_src;
    logic [WIDTH-1:0]                l3;
    logic                            s1_l2;
    logic                            s2_l2;
    logic                            s2_l3;
    logic [WIDTH-1:0]                y_q;

    assign lane = bus.data;

    for (genvar k = 0; k < N1; k++) begin : g_l1
        mux_21 #(.WIDTH(WIDTH)) u_cell (
            .in0 (lane[2*k]),
            .in1 (lane[2*k+1]),
            .sel (bus.s0),
            .out (l1[k])
        );
    end

`ifdef MUX_81_PIPE_EN
    // Upper select bits travel with their data so each result uses its own cycle's selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1_src <= '0;
            s1_l2  <= 1'b0;
            s2_l2  <= 1'b0;
        end else begin
            l1_src <= l1;
            s1_l2  <= bus.s1;
            s2_l2  <= bus.s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l2_src <= '0;
            s2_l3  <= 1'b0;
        end else begin
            l2_src <= l2;
            s2_l3  <= s2_l2;
        end
    end
`else
    assign l1_src = l1;
    assign s1_l2  = bus.s1;
    assign s2_l2  = bus.s2;
    assign l2_src = l2;
    assign s2_l3  = s2_l2;
`endif

    for (genvar k = 0; k < N2; k++) begin : g_l2
        mux_21 #(.WIDTH(WIDTH)) u_cell (
            .in0 (l1_src[2*k]),
            .in1 (l1_src[2*k+1]),
            .sel (s1_l2),
            .out (l2[k])
        );
    end

    for (genvar k = 0; k < 1; k++) begin : g_l3
        mux_21 #(.WIDTH(WIDTH)) u_cell (
            .in0 (l2_src[0]),
            .in1 (l2_src[1]),
            .sel (s2_l3),
            .out (l3)
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= '0;
        else        y_q <= l3;
    end

    assign bus.y = y_q;
endmodule

// File: tb/tb_mux_81.sv
// Scoreboard bench for mux_81: a 1-bit-lane and a 4-bit-lane instance driven with the same selects.
module tb_mux_81;
`ifdef MUX_81_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic       e1;
        logic [3:0] e4;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    mux_81_if #(.WIDTH(1)) bus1 ();
    mux_81_if #(.WIDTH(4)) bus4 ();

    mux_81 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mux_81 #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d1, input logic [31:0] d4, input logic [2:0] sel);
        bus1.data = d1;
        bus4.data = d4;
        {bus1.s2, bus1.s1, bus1.s0} = sel;
        {bus4.s2, bus4.s1, bus4.s0} = sel;
    endtask

    function automatic exp_t model(input logic [7:0] d1, input logic [31:0] d4, input logic [2:0] sel);
        exp_t e;
        e.e1 = d1[sel];
        e.e4 = d4[sel*4 +: 4];
        return e;
    endfunction

    // Results still in flight after reset release are all-zero.
    task automatic prefill();
        exp_t z;
        z.e1 = 1'b0;
        z.e4 = 4'h0;
        sb.delete();
        for (int i = 0; i < LAT - 1; i++) sb.push_back(z);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() >= LAT) begin
            e = sb.pop_front();
            check({tag, "_w1"}, bus1.y, e.e1);
            check({tag, "_w4"}, bus4.y, e.e4);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] d1, input logic [31:0] d4, input logic [2:0] sel);
        @(negedge clk);
        drive(d1, d4, sel);
        sb.push_back(model(d1, d4, sel));
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] lanes4;
        logic [31:0] r4;
        logic [7:0]  r1;
        lanes4 = 32'h7654_3210;

        rst_n = 1'b0;
        drive(8'hA5, lanes4, 3'd7);
        #1;
        check("rst_async_w1", bus1.y, 0);
        check("rst_async_w4", bus4.y, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold_w1", bus1.y, 0);
            check("rst_hold_w4", bus4.y, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prefill();

        for (int s = 0; s < 8; s++) step("sweep", 8'b1010_0101, lanes4, 3'(s));

        for (int i = 0; i < 8; i++)
            for (int s = 0; s < 8; s++) begin
                r4 = $urandom;
                step("walk", 8'(1 << i), r4, 3'(s));
            end

        repeat (6) begin
            step("held", 8'h08, lanes4, 3'd3);
            step("held", 8'hF7, ~lanes4, 3'd3);
        end

        repeat (LAT + 1) step("glitch_pre", 8'h04, lanes4, 3'd2);
        @(negedge clk);
        drive(8'h04, lanes4, 3'd5);
        #2;
        check("glitch_mid_w1", bus1.y, 1);
        check("glitch_mid_w4", bus4.y, 2);
        drive(8'h04, lanes4, 3'd2);
        sb.push_back(model(8'h04, lanes4, 3'd2));
        @(posedge clk);
        #1;
        pop_check("glitch");

        repeat (24) begin
            r1 = 8'($urandom);
            r4 = $urandom;
            step("rand", r1, r4, 3'($urandom_range(0, 7)));
        end

        repeat (LAT) step("fill", 8'hFF, 32'hFFFF_FFFF, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_w1", bus1.y, 0);
        check("rst_mid_w4", bus4.y, 0);
        sb.delete();
        @(posedge clk);
        #1;
        check("rst_mid_hold_w4", bus4.y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prefill();
        for (int s = 7; s >= 0; s--) step("post_rst", 8'hFF, lanes4, 3'(s));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mux_81.md
# mux_81

Registered 8-to-1 multiplexer built as a three-level tree of 2-to-1 multiplexer cells. It selects one of eight data lanes using three separate select bits (s2 = MSB, s0 = LSB) and drives the selected lane on a registered output. It is a leaf datapath block that is instantiated wherever a clocked wide-select bit or lane picker is needed.

## Interface
Parameters:
- `WIDTH`, default 1: width of each data lane in bits. Default 1 gives an 8-bit `data` bus and a 1-bit `y`.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `data`  input  8*WIDTH  eight lanes; lane i = `data[i*WIDTH +: WIDTH]`.
- `s2`  input  1  select MSB.
- `s1`  input  1  select middle bit.
- `s0`  input  1  select LSB.
- `y`  output  WIDTH  registered selected lane.

## Operation
- Select index sel = {s2,s1,s0}, unsigned 0..7. Result is lane[sel]; all eight values are valid, so no out-of-range case exists.
- Tree, level 1: four cells controlled by s0 pick lane 2k+s0 for k = 0..3.
- Tree, level 2: two cells controlled by s1 pick among the level-1 results.
- Tree, level 3: one cell controlled by s2 gives the final result.
- 2-to-1 cell: out = sel ? in1 : in0. Purely combinational, no state.
- Output `y` is taken only from a register. It never passes combinationally from the inputs.
- Reset: while `rst_n` = 0, `y` and every pipeline register are 0. This takes effect immediately and does not wait for `clk`.
- X or Z on the selects must not be masked by the design. Plain ternary cells are acceptable.

## Timing
- Default build: inputs are sampled on a `clk` rising edge. `y` shows lane[sel] for those sampled values after that edge, so latency is 1 cycle.
- A select or data change between edges has no effect on `y` until the next edge.
- Reset assertion mid-operation: `y` goes to 0 immediately.
- Reset release: the first rising edge with `rst_n` = 1 loads the current selection.
- Back-to-back select changes every cycle give one new result per cycle. Throughput is 1 per cycle.

## Configuration
- Macro `MUX_81_PIPE_EN`.
- Undefined (default): the tree is fully combinational, with a single output register. Latency is 1 cycle.
- Defined: a register stage sits after level 1 and after level 2, in addition to the output register. Latency is 3 cycles and throughput stays 1 per cycle.
  - The s1 and s2 values are delayed with their data so each result matches the select bits sampled in the same cycle as its data.
  - All pipeline registers reset to 0 asynchronously.
  - For the first 2 cycles after reset release, `y` shows 0.

## Structure
- The shared package `mux_pkg` holds:
  - the lane-count constant, 8;
  - the select-width constant, 3;
  - the pipeline-latency constants, 1 and 3.
- Sub-module `mux_21`: parameterised by `WIDTH`, with ports `in0`, `in1`, `sel`, `out`. It is instantiated 7 times with generate loops, per level.

## Test plan
- Reset: hold `rst_n` = 0 with `data` = 8'hA5 and sel = 7, and toggle `clk` -> `y` = 0 throughout. Assert `rst_n` low in the middle of a cycle -> `y` = 0 with no clock edge.
- Full sweep: `data` = 8'b1010_0101, sel stepped 0..7, one value per cycle -> after the latency, `y` sequence is 1,0,1,0,0,1,0,1.
- Walking one: `data` = 1<<i for i = 0..7, sel = i -> `y` = 1. Any sel ≠ i -> `y` = 0.
- Held selection: sel = 3 with `data` toggling between 8'h08 and 8'hF7 each cycle -> `y` alternates 1,0 with the configured latency.
- Glitch immunity: sel changes to 5 and back to 2 between two edges, with `data` = 8'h04 -> `y` stays 1 and does not change.
- Pipelined build (`MUX_81_PIPE_EN`) with `WIDTH` = 4: lanes = {7,6,...,0}, sel stepped 0..7 -> `y` = 0..7, each value appearing exactly 3 cycles after its select.
